motor_cmd_ramp: RTL and testbench

Slew-rate limiter and command watchdog that sits between the SPI command decoder and one PWM instance; one instance per axis (pitch, yaw).
- Accepts raw enable/direction/duty writes from the SPI slave.
- Moves the applied duty toward the target in fixed steps at a fixed update rate.
- Forces reversals through zero duty.
- Ramps the motor to stop if no command arrives within the watchdog window.

---
 rtl/motor_cmd_ramp_pkg.sv | 30 +++
 rtl/motor_cmd_ramp_tick_gen.sv | 31 +++
 rtl/motor_cmd_ramp.sv | 142 ++++++++++++++
 tb/tb_motor_cmd_ramp.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_cmd_ramp_pkg.sv
// Shared definitions for the motor command ramp: FSM state encoding,
// timing derivations and the duty width shared with the PWM block.
package motor_cmd_ramp_pkg;

    // Duty width; the PWM instance downstream uses the same value.
    localparam int COUNTER_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        BRAKE = 2'd2,
        HOLD  = 2'd3
    } ramp_state_e;

    // Clocks per ramp update; never below one so the tick stays defined.
    function automatic int calc_tick_div(input int clk_freq, input int ramp_hz);
        int div;
        div = clk_freq / ramp_hz;
        return (div < 1) ? 1 : div;
    endfunction

    // Clocks in the command watchdog window; kept at two or more so the
    // counter has a real terminal value.
    function automatic int calc_wdt_cycles(input int clk_freq, input int wdt_ms);
        int cyc;
        cyc = clk_freq / 1000 * wdt_ms;
        return (cyc < 2) ? 2 : cyc;
    endfunction

endpackage

// File: rtl/motor_cmd_ramp_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every TICK_DIV clocks.
module ramp_tick_gen #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..TICK_DIV-1 and raise tick on the cycle the count wraps to 0.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/motor_cmd_ramp.sv
// Slew-rate limiter and command watchdog between the SPI command decoder and
// one PWM channel. The applied duty walks toward the latched target by at
// most STEP per tick, reversals pass through zero, and a silent command link
// ramps the motor down to stop.
module motor_cmd_ramp
    import motor_cmd_ramp_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int COUNTER_W = COUNTER_W_DEFAULT,
    parameter int RAMP_HZ   = 10000,
    parameter int STEP      = 16,
    parameter int WDT_MS    = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic                 cmd_enable,
    input  logic                 cmd_direction,
    input  logic [COUNTER_W-1:0] cmd_duty,
    output logic                 out_enable,
    output logic                 out_direction,
    output logic [COUNTER_W-1:0] out_duty,
    output logic                 timeout,
    output logic                 busy
);

    localparam int TICK_DIV   = calc_tick_div(CLK_FREQ, RAMP_HZ);
    localparam int WDT_CYCLES = calc_wdt_cycles(CLK_FREQ, WDT_MS);
    localparam int WDT_W      = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0]     WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    localparam logic [COUNTER_W-1:0] STEP_V   = COUNTER_W'(STEP);

    ramp_state_e          state, state_n;
    logic [COUNTER_W-1:0] mag, mag_n;
    logic                 dir_n;
    logic [COUNTER_W-1:0] tgt_mag;
    logic                 tgt_dir;
    logic [WDT_W-1:0]     wdt_cnt;
    logic                 tick;

    // Largest legal move for a given remaining distance; clamping to the
    // gap is what keeps the duty from overshooting or wrapping.
    function automatic logic [COUNTER_W-1:0] limit_step(input logic [COUNTER_W-1:0] gap);
        return (gap < STEP_V) ? gap : STEP_V;
    endfunction

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Latch the commanded target, run the watchdog and clear it on any command.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_mag <= '0;
            tgt_dir <= 1'b0;
            wdt_cnt <= '0;
            timeout <= 1'b0;
        end else if (cmd_valid) begin
            tgt_mag <= cmd_enable ? cmd_duty : '0;
            tgt_dir <= cmd_direction;
            wdt_cnt <= '0;
            timeout <= 1'b0;
        end else if (wdt_cnt == WDT_LAST) begin
            // Counter saturates here; the stop target is simply re-applied.
            timeout <= 1'b1;
            tgt_mag <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    // Next-state and next-duty decision, acting only on ramp ticks.
    // NOTE: every signal driven here gets a default first, so paths that do
    // not assign it cannot infer a latch.
    always_comb begin
        state_n = state;
        mag_n   = mag;
        dir_n   = out_direction;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (tgt_mag != '0) begin
                        dir_n   = tgt_dir;
                        state_n = RAMP;
                    end
                end
                RAMP: begin
                    if (out_direction != tgt_dir) begin
                        state_n = BRAKE;
                    end else begin
                        if (tgt_mag > mag) begin
                            mag_n = mag + limit_step(tgt_mag - mag);
                        end else if (tgt_mag < mag) begin
                            mag_n = mag - limit_step(mag - tgt_mag);
                        end
                        if (mag_n == tgt_mag) begin
                            state_n = (tgt_mag == '0) ? IDLE : HOLD;
                        end
                    end
                end
                BRAKE: begin
                    mag_n = mag - limit_step(mag);
                    if (mag_n == '0) begin
                        dir_n   = tgt_dir;
                        state_n = (tgt_mag != '0) ? RAMP : IDLE;
                    end
                end
                HOLD: begin
                    if (out_direction != tgt_dir) begin
                        state_n = BRAKE;
                    end else if (tgt_mag != mag) begin
                        state_n = RAMP;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Register the applied duty, direction, enable and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mag           <= '0;
            out_direction <= 1'b0;
            out_enable    <= 1'b0;
        end else begin
            state         <= state_n;
            mag           <= mag_n;
            out_direction <= dir_n;
            out_enable    <= (mag_n != '0);
        end
    end

    assign out_duty = mag;
    assign busy     = (state == RAMP) || (state == BRAKE);

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Self-checking bench for motor_cmd_ramp. Instance A uses a long watchdog
// for ramp/reversal/reset/full-scale scenarios; instance B uses a 50-cycle
// watchdog for timeout scenarios. Expected duty steps are queued when a
// command is driven and popped whenever the DUT's out_duty changes.
module tb_motor_cmd_ramp;

    typedef struct packed {
        logic [11:0] duty;
        logic        dir;
        logic        en;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_valid, a_en, a_dir;
    logic [11:0] a_duty_in;
    logic        a_en_o, a_dir_o, a_timeout, a_busy;
    logic [11:0] a_duty_o;

    logic        b_valid, b_en, b_dir;
    logic [11:0] b_duty_in;
    logic        b_en_o, b_dir_o, b_timeout, b_busy;
    logic [11:0] b_duty_o;

    exp_t        qa[$];
    exp_t        qb[$];
    int          total = 0;
    int          bad   = 0;
    bit          mon_on = 1'b0;
    logic [11:0] prev_a, prev_b;

    always #5 clk = ~clk;

    motor_cmd_ramp #(
        .CLK_FREQ (1000), .COUNTER_W (12), .RAMP_HZ (100), .STEP (16), .WDT_MS (1000)
    ) dut_a (
        .clk (clk), .reset (reset),
        .cmd_valid (a_valid), .cmd_enable (a_en), .cmd_direction (a_dir), .cmd_duty (a_duty_in),
        .out_enable (a_en_o), .out_direction (a_dir_o), .out_duty (a_duty_o),
        .timeout (a_timeout), .busy (a_busy)
    );

    motor_cmd_ramp #(
        .CLK_FREQ (1000), .COUNTER_W (12), .RAMP_HZ (100), .STEP (16), .WDT_MS (50)
    ) dut_b (
        .clk (clk), .reset (reset),
        .cmd_valid (b_valid), .cmd_enable (b_en), .cmd_direction (b_dir), .cmd_duty (b_duty_in),
        .out_enable (b_en_o), .out_direction (b_dir_o), .out_duty (b_duty_o),
        .timeout (b_timeout), .busy (b_busy)
    );

    // ---------------- stimulus helpers ----------------
    // Each command is sampled on exactly one rising edge; returns on the
    // falling edge right after that sample edge.
    task automatic cmd_a(input logic en, input logic dir, input logic [11:0] duty);
        @(negedge clk);
        a_valid = 1'b1; a_en = en; a_dir = dir; a_duty_in = duty;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic cmd_b(input logic en, input logic dir, input logic [11:0] duty);
        @(negedge clk);
        b_valid = 1'b1; b_en = en; b_dir = dir; b_duty_in = duty;
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    task automatic push_exp(input bit to_b, input int duty, input logic dir);
        exp_t e;
        e.duty = 12'(duty);
        e.dir  = dir;
        e.en   = (duty != 0);
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    // Reference slew model: step by at most 16 toward the target.
    task automatic push_ramp(input bit to_b, input int from, input int to, input logic dir);
        int m;
        m = from;
        while (m != to) begin
            if (to > m) m += ((to - m) < 16) ? (to - m) : 16;
            else        m -= ((m - to) < 16) ? (m - to) : 16;
            push_exp(to_b, m, dir);
        end
    endtask

    task automatic wait_empty(input bit which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? qb.size() : qa.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- scoreboard comparators ----------------
    task automatic mon_a();
        exp_t e;
        if (a_duty_o !== prev_a) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_step: got duty=%0d dir=%0b en=%0b, no step expected",
                         a_duty_o, a_dir_o, a_en_o);
            end else begin
                e = qa.pop_front();
                if ({a_duty_o, a_dir_o, a_en_o} !== e) begin
                    bad++;
                    $display("FAIL a_step: got duty=%0d dir=%0b en=%0b, want duty=%0d dir=%0b en=%0b",
                             a_duty_o, a_dir_o, a_en_o, e.duty, e.dir, e.en);
                end
            end
            prev_a = a_duty_o;
        end
    endtask

    task automatic mon_b();
        exp_t e;
        if (b_duty_o !== prev_b) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_step: got duty=%0d dir=%0b en=%0b, no step expected",
                         b_duty_o, b_dir_o, b_en_o);
            end else begin
                e = qb.pop_front();
                if ({b_duty_o, b_dir_o, b_en_o} !== e) begin
                    bad++;
                    $display("FAIL b_step: got duty=%0d dir=%0b en=%0b, want duty=%0d dir=%0b en=%0b",
                             b_duty_o, b_dir_o, b_en_o, e.duty, e.dir, e.en);
                end
            end
            prev_b = b_duty_o;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        a_valid = 1'b0; a_en = 1'b0; a_dir = 1'b0; a_duty_in = '0;
        b_valid = 1'b0; b_en = 1'b0; b_dir = 1'b0; b_duty_in = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({a_duty_o, a_en_o, a_dir_o, a_timeout, a_busy} !== 16'h0) begin
            bad++;
            $display("FAIL reset_a: got duty=%0d en=%0b dir=%0b to=%0b busy=%0b, want all 0",
                     a_duty_o, a_en_o, a_dir_o, a_timeout, a_busy);
        end
        total++;
        if ({b_duty_o, b_en_o, b_dir_o, b_timeout, b_busy} !== 16'h0) begin
            bad++;
            $display("FAIL reset_b: got duty=%0d en=%0b dir=%0b to=%0b busy=%0b, want all 0",
                     b_duty_o, b_en_o, b_dir_o, b_timeout, b_busy);
        end
        reset  = 1'b0;
        prev_a = '0;
        prev_b = '0;
        mon_on = 1'b1;
    endtask

    task automatic test_watchdog();
        bit ok;
        push_ramp(1'b1, 0, 40, 1'b0);
        push_ramp(1'b1, 40, 0, 1'b0);
        cmd_b(1'b1, 1'b0, 12'd40);
        total++;
        if (b_timeout !== 1'b0) begin
            bad++; $display("FAIL wdt_clear_on_cmd: got timeout=%0b want 0", b_timeout);
        end
        repeat (49) @(negedge clk);
        total++;
        if (b_timeout !== 1'b0) begin
            bad++; $display("FAIL wdt_early: at cycle 49 got timeout=%0b want 0", b_timeout);
        end
        @(negedge clk);
        total++;
        if (b_timeout !== 1'b1) begin
            bad++; $display("FAIL wdt_expire: at cycle 50 got timeout=%0b want 1", b_timeout);
        end
        wait_empty(1'b1, 200, ok);
        total++;
        if (!ok || b_en_o !== 1'b0 || b_busy !== 1'b0 || b_timeout !== 1'b1) begin
            bad++;
            $display("FAIL wdt_rampdown: got done=%0b en=%0b busy=%0b to=%0b want 1 0 0 1",
                     ok, b_en_o, b_busy, b_timeout);
        end
        cmd_b(1'b0, 1'b0, 12'd0);
        total++;
        if (b_timeout !== 1'b0) begin
            bad++; $display("FAIL wdt_sticky_clear: got timeout=%0b want 0", b_timeout);
        end
    endtask

    task automatic test_wdt_collision();
        bit ok;
        push_ramp(1'b1, 0, 32, 1'b0);
        cmd_b(1'b1, 1'b0, 12'd32);
        repeat (48) @(negedge clk);
        push_ramp(1'b1, 32, 48, 1'b0);
        cmd_b(1'b1, 1'b0, 12'd48);   // sampled on the expiry edge
        total++;
        if (b_timeout !== 1'b0) begin
            bad++; $display("FAIL wdt_collision: got timeout=%0b want 0", b_timeout);
        end
        wait_empty(1'b1, 100, ok);
        total++;
        if (!ok || b_duty_o !== 12'd48 || b_timeout !== 1'b0) begin
            bad++;
            $display("FAIL wdt_collision_target: got done=%0b duty=%0d to=%0b want 1 48 0",
                     ok, b_duty_o, b_timeout);
        end
        push_ramp(1'b1, 48, 0, 1'b0);
        cmd_b(1'b0, 1'b0, 12'd0);
        wait_empty(1'b1, 100, ok);
        total++;
        if (!ok || b_duty_o !== 12'd0) begin
            bad++; $display("FAIL b_stop: got done=%0b duty=%0d want 1 0", ok, b_duty_o);
        end
    endtask

    task automatic test_ramp_up();
        bit ok;
        push_ramp(1'b0, 0, 100, 1'b0);
        cmd_a(1'b1, 1'b0, 12'd100);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_duty_o == 12'd16) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok || a_busy !== 1'b1 || a_en_o !== 1'b1 || a_timeout !== 1'b0) begin
            bad++;
            $display("FAIL ramp_first_step: got seen=%0b busy=%0b en=%0b to=%0b want 1 1 1 0",
                     ok, a_busy, a_en_o, a_timeout);
        end
        wait_empty(1'b0, 200, ok);
        total++;
        if (!ok || a_duty_o !== 12'd100 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL ramp_hold: got done=%0b duty=%0d busy=%0b want 1 100 0",
                     ok, a_duty_o, a_busy);
        end
    endtask

    task automatic test_reversal();
        bit ok;
        push_ramp(1'b0, 100, 4, 1'b0);
        push_exp(1'b0, 0, 1'b1);
        push_ramp(1'b0, 0, 50, 1'b1);
        cmd_a(1'b1, 1'b1, 12'd50);
        repeat (25) @(negedge clk);
        total++;
        if (a_busy !== 1'b1 || a_dir_o !== 1'b0) begin
            bad++;
            $display("FAIL reversal_brake: got busy=%0b dir=%0b want 1 0", a_busy, a_dir_o);
        end
        wait_empty(1'b0, 300, ok);
        total++;
        if (!ok || a_duty_o !== 12'd50 || a_dir_o !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reversal_end: got done=%0b duty=%0d dir=%0b busy=%0b want 1 50 1 0",
                     ok, a_duty_o, a_dir_o, a_busy);
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit ok;
        push_exp(1'b0, 0, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        push_ramp(1'b0, 0, 64, 1'b0);
        cmd_a(1'b1, 1'b0, 12'd200);
        wait_empty(1'b0, 200, ok);
        total++;
        if (!ok || a_duty_o !== 12'd64 || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_ramp: got done=%0b duty=%0d busy=%0b want 1 64 1",
                     ok, a_duty_o, a_busy);
        end
        push_exp(1'b0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({a_duty_o, a_en_o, a_dir_o, a_timeout, a_busy} !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_ramp: got duty=%0d en=%0b dir=%0b to=%0b busy=%0b want all 0",
                     a_duty_o, a_en_o, a_dir_o, a_timeout, a_busy);
        end
        repeat (40) @(negedge clk);
        total++;
        if (a_duty_o !== 12'd0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_rampdown: got duty=%0d busy=%0b want 0 0", a_duty_o, a_busy);
        end
    endtask

    task automatic test_full_scale();
        bit ok;
        cmd_a(1'b0, 1'b0, 12'd4095);
        repeat (50) @(negedge clk);
        total++;
        if (a_duty_o !== 12'd0 || a_en_o !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL disabled_cmd: got duty=%0d en=%0b busy=%0b want 0 0 0",
                     a_duty_o, a_en_o, a_busy);
        end
        push_ramp(1'b0, 0, 4095, 1'b0);
        cmd_a(1'b1, 1'b0, 12'd4095);
        for (int r = 0; r < 10 && qa.size() != 0; r++) begin
            repeat (400) @(negedge clk);
            cmd_a(1'b1, 1'b0, 12'd4095);   // refresh keeps the watchdog quiet
        end
        wait_empty(1'b0, 100, ok);
        total++;
        if (!ok || a_duty_o !== 12'd4095 || a_en_o !== 1'b1 || a_busy !== 1'b0 || a_timeout !== 1'b0) begin
            bad++;
            $display("FAIL full_scale: got done=%0b duty=%0d en=%0b busy=%0b to=%0b want 1 4095 1 0 0",
                     ok, a_duty_o, a_en_o, a_busy, a_timeout);
        end
    endtask

    initial begin
        fork
            forever begin @(negedge clk); if (mon_on) mon_a(); end
            forever begin @(negedge clk); if (mon_on) mon_b(); end
        join_none
        test_reset();
        test_watchdog();
        test_wdt_collision();
        test_ramp_up();
        test_reversal();
        test_reset_mid_ramp();
        test_full_scale();
        repeat (2) @(negedge clk);
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL leftover_steps: got a=%0d b=%0d pending, want 0 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
